// File: rtl/ex_mem_skid_register.sv
// EX/MEM pipeline register with valid/ready handshake and one-entry skid buffer.
// In_Ready is a pure register output, so MEM backpressure never reaches EX combinationally.
module ex_mem_skid_register #(
  parameter int RegWidth    = 16,
  parameter int AddrBits    = 3,
  parameter int ControlBits = 4,
  parameter int RegWriteBit = 0
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   Flush,
  input  logic                   In_Valid,
  output logic                   In_Ready,
  input  logic [ControlBits-1:0] Control_In,
  input  logic [RegWidth-1:0]    ALUOut_In,
  input  logic [RegWidth-1:0]    MemData_In,
  input  logic [AddrBits-1:0]    DestReg_In,
  output logic                   Out_Valid,
  input  logic                   Out_Ready,
  output logic [ControlBits-1:0] Control_Out,
  output logic [RegWidth-1:0]    ALUOut_Out,
  output logic [RegWidth-1:0]    MemData_Out,
  output logic [AddrBits-1:0]    DestReg_Out,
  output logic [1:0]             Occupancy,
  output logic                   Fwd_RegWrite,
  output logic [AddrBits-1:0]    Fwd_DestReg
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic r_main_valid;
  logic r_skid_valid;

  logic [ControlBits-1:0] r_main_ctrl;
  logic [RegWidth-1:0]    r_main_alu;
  logic [RegWidth-1:0]    r_main_mem;
  logic [AddrBits-1:0]    r_main_dest;
  logic [ControlBits-1:0] r_skid_ctrl;
  logic [RegWidth-1:0]    r_skid_alu;
  logic [RegWidth-1:0]    r_skid_mem;
  logic [AddrBits-1:0]    r_skid_dest;

  logic w_in_fire;
  logic w_out_fire;
  logic w_load_main_in;
  logic w_load_main_skid;
  logic w_load_skid;

  assign In_Ready   = !r_skid_valid;
  assign Out_Valid  = r_main_valid;
  assign w_in_fire  = In_Valid & In_Ready;
  assign w_out_fire = r_main_valid & Out_Ready;

  always_comb begin
    w_state_next     = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    unique case (r_state)
      S_EMPTY: begin
        if (w_in_fire) begin
          w_load_main_in = 1'b1;
          w_state_next   = S_ONE;
        end
      end
      S_ONE: begin
        if (w_in_fire && w_out_fire) begin
          w_load_main_in = 1'b1;
        end else if (w_in_fire) begin
          w_load_skid  = 1'b1;
          w_state_next = S_FULL;
        end else if (w_out_fire) begin
          w_state_next = S_EMPTY;
        end
      end
      S_FULL: begin
        if (w_out_fire) begin
          w_load_main_skid = 1'b1;
          w_state_next     = S_ONE;
        end
      end
      default: w_state_next = S_EMPTY;
    endcase
  end

  // Reset and flush share one clearing path; reset simply wins by being OR'd in.
  always_ff @(posedge CLK) begin
    if (RST || Flush) begin
      r_state      <= S_EMPTY;
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_main_ctrl  <= '0;
      r_main_alu   <= '0;
      r_main_mem   <= '0;
      r_main_dest  <= '0;
      r_skid_ctrl  <= '0;
      r_skid_alu   <= '0;
      r_skid_mem   <= '0;
      r_skid_dest  <= '0;
    end else begin
      r_state      <= w_state_next;
      r_main_valid <= (w_state_next != S_EMPTY);
      r_skid_valid <= (w_state_next == S_FULL);
      if (w_load_main_in) begin
        r_main_ctrl <= Control_In;
        r_main_alu  <= ALUOut_In;
        r_main_mem  <= MemData_In;
        r_main_dest <= DestReg_In;
      end else if (w_load_main_skid) begin
        r_main_ctrl <= r_skid_ctrl;
        r_main_alu  <= r_skid_alu;
        r_main_mem  <= r_skid_mem;
        r_main_dest <= r_skid_dest;
      end
      if (w_load_skid) begin
        r_skid_ctrl <= Control_In;
        r_skid_alu  <= ALUOut_In;
        r_skid_mem  <= MemData_In;
        r_skid_dest <= DestReg_In;
      end
    end
  end

  assign Control_Out  = r_main_ctrl;
  assign ALUOut_Out   = r_main_alu;
  assign MemData_Out  = r_main_mem;
  assign DestReg_Out  = r_main_dest;
  assign Occupancy    = {r_skid_valid, r_main_valid & ~r_skid_valid};
  assign Fwd_RegWrite = r_main_valid & r_main_ctrl[RegWriteBit];
  assign Fwd_DestReg  = r_main_dest;

endmodule

// File: tb/tb_ex_mem_skid_register.sv
// Directed and randomized checks of the EX/MEM skid register against a queue model.
module tb_ex_mem_skid_register;

  logic        CLK = 1'b0;
  logic        RST;
  logic        Flush;
  logic        In_Valid;
  logic        In_Ready;
  logic [3:0]  Control_In;
  logic [15:0] ALUOut_In;
  logic [15:0] MemData_In;
  logic [2:0]  DestReg_In;
  logic        Out_Valid;
  logic        Out_Ready;
  logic [3:0]  Control_Out;
  logic [15:0] ALUOut_Out;
  logic [15:0] MemData_Out;
  logic [2:0]  DestReg_Out;
  logic [1:0]  Occupancy;
  logic        Fwd_RegWrite;
  logic [2:0]  Fwd_DestReg;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  ex_mem_skid_register #(
    .RegWidth(16),
    .AddrBits(3),
    .ControlBits(4),
    .RegWriteBit(0)
  ) dut (
    .CLK(CLK), .RST(RST), .Flush(Flush),
    .In_Valid(In_Valid), .In_Ready(In_Ready),
    .Control_In(Control_In), .ALUOut_In(ALUOut_In),
    .MemData_In(MemData_In), .DestReg_In(DestReg_In),
    .Out_Valid(Out_Valid), .Out_Ready(Out_Ready),
    .Control_Out(Control_Out), .ALUOut_Out(ALUOut_Out),
    .MemData_Out(MemData_Out), .DestReg_Out(DestReg_Out),
    .Occupancy(Occupancy), .Fwd_RegWrite(Fwd_RegWrite), .Fwd_DestReg(Fwd_DestReg)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] c, input logic [15:0] a,
                       input logic [15:0] m, input logic [2:0] d);
    In_Valid   = v;
    Control_In = c;
    ALUOut_In  = a;
    MemData_In = m;
    DestReg_In = d;
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".valid"}, 64'(Out_Valid), 64'd0);
    check({tag, ".occ"}, 64'(Occupancy), 64'd0);
    check({tag, ".ready"}, 64'(In_Ready), 64'd1);
    check({tag, ".payload"}, 64'({Control_Out, ALUOut_Out, MemData_Out, DestReg_Out}), 64'd0);
    check({tag, ".fwd"}, 64'({Fwd_RegWrite, Fwd_DestReg}), 64'd0);
  endtask

  logic [38:0] q[$];
  logic [38:0] head;
  logic        m_in_fire;
  logic        m_out_fire;

  initial begin
    RST = 1'b1; Flush = 1'b0; Out_Ready = 1'b0;
    drive(1'b0, '0, '0, '0, '0);
    step();
    RST = 1'b0;
    check_idle("reset");

    // Streaming
    Out_Ready = 1'b1;
    drive(1'b1, 4'd4, 16'd35, 16'd45, 3'd5);
    step();
    check("s1.valid", 64'(Out_Valid), 64'd1);
    check("s1.alu", 64'(ALUOut_Out), 64'd35);
    check("s1.mem", 64'(MemData_Out), 64'd45);
    check("s1.occ", 64'(Occupancy), 64'd1);
    check("s1.fwdw", 64'(Fwd_RegWrite), 64'd0);
    drive(1'b1, 4'd1, 16'd7, 16'd9, 3'd2);
    step();
    check("s2.alu", 64'(ALUOut_Out), 64'd7);
    check("s2.occ", 64'(Occupancy), 64'd1);
    check("s2.fwdw", 64'(Fwd_RegWrite), 64'd1);
    check("s2.fwdd", 64'(Fwd_DestReg), 64'd2);
    drive(1'b0, '0, '0, '0, '0);
    step();
    check("s3.valid", 64'(Out_Valid), 64'd0);
    check("s3.fwdw", 64'(Fwd_RegWrite), 64'd0);

    // Backpressure
    Out_Ready = 1'b0;
    drive(1'b1, 4'd0, 16'd35, 16'd1, 3'd1);
    step();
    check("bp.a.alu", 64'(ALUOut_Out), 64'd35);
    check("bp.a.ready", 64'(In_Ready), 64'd1);
    drive(1'b1, 4'd0, 16'd36, 16'd2, 3'd2);
    step();
    check("bp.b.occ", 64'(Occupancy), 64'd2);
    check("bp.b.ready", 64'(In_Ready), 64'd0);
    check("bp.b.alu", 64'(ALUOut_Out), 64'd35);
    drive(1'b1, 4'd0, 16'd37, 16'd3, 3'd3);
    step();
    check("bp.c.occ", 64'(Occupancy), 64'd2);
    check("bp.c.alu", 64'(ALUOut_Out), 64'd35);
    Out_Ready = 1'b1;
    step();
    check("bp.rel1.alu", 64'(ALUOut_Out), 64'd36);
    check("bp.rel1.occ", 64'(Occupancy), 64'd1);
    check("bp.rel1.ready", 64'(In_Ready), 64'd1);
    step();
    check("bp.rel2.alu", 64'(ALUOut_Out), 64'd37);
    check("bp.rel2.valid", 64'(Out_Valid), 64'd1);
    drive(1'b0, '0, '0, '0, '0);
    step();
    check("bp.drain", 64'(Occupancy), 64'd0);

    // Flush while full
    Out_Ready = 1'b0;
    drive(1'b1, 4'd1, 16'd50, 16'd5, 3'd4);
    step();
    drive(1'b1, 4'd1, 16'd51, 16'd5, 3'd4);
    step();
    check("fl.pre.occ", 64'(Occupancy), 64'd2);
    Flush = 1'b1;
    drive(1'b1, 4'd1, 16'd52, 16'd5, 3'd4);
    step();
    Flush = 1'b0;
    check_idle("flush");
    drive(1'b0, '0, '0, '0, '0);
    step();
    check("fl.post.valid", 64'(Out_Valid), 64'd0);

    // Mid-run reset
    drive(1'b1, 4'd1, 16'd60, 16'd6, 3'd6);
    step();
    drive(1'b1, 4'd1, 16'd61, 16'd6, 3'd6);
    step();
    check("mr.pre.occ", 64'(Occupancy), 64'd2);
    RST = 1'b1;
    drive(1'b0, '0, '0, '0, '0);
    step();
    RST = 1'b0;
    check_idle("midreset");
    Out_Ready = 1'b1;
    drive(1'b1, 4'd0, 16'd99, 16'd0, 3'd0);
    step();
    check("mr.next.alu", 64'(ALUOut_Out), 64'd99);
    check("mr.next.valid", 64'(Out_Valid), 64'd1);
    drive(1'b0, '0, '0, '0, '0);
    step();

    // Random traffic against a queue model (DUT is empty here)
    q.delete();
    for (int i = 0; i < 2000; i++) begin
      drive(1'($urandom), 4'($urandom), 16'($urandom), 16'($urandom), 3'($urandom));
      Out_Ready = 1'($urandom);
      Flush     = ($urandom_range(0, 19) == 0);
      #1;
      check("rnd.valid", 64'(Out_Valid), 64'(q.size() > 0));
      check("rnd.occ", 64'(Occupancy), 64'(q.size()));
      check("rnd.ready", 64'(In_Ready), 64'(q.size() < 2));
      if (q.size() > 0) begin
        head = q[0];
        check("rnd.head", 64'({Control_Out, ALUOut_Out, MemData_Out, DestReg_Out}), 64'(head));
        check("rnd.fwdw", 64'(Fwd_RegWrite), 64'(head[35]));
      end else begin
        check("rnd.fwdw.idle", 64'(Fwd_RegWrite), 64'd0);
      end
      Out_Ready = ~Out_Ready;
      #1;
      check("rnd.ready.comb", 64'(In_Ready), 64'(q.size() < 2));
      Out_Ready = ~Out_Ready;
      m_in_fire  = In_Valid && (q.size() < 2);
      m_out_fire = Out_Ready && (q.size() > 0);
      if (Flush) begin
        q.delete();
      end else begin
        if (m_out_fire) void'(q.pop_front());
        if (m_in_fire) q.push_back({Control_In, ALUOut_In, MemData_In, DestReg_In});
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
